sseg_capture: RTL and testbench

Receive-side companion to the four-digit multiplexed seven-segment driver. Samples the active-low segment bus and digit-enable lines, filters out multiplex transitions and decodes each settled digit slot back to a BCD/code nibble. Assembles the four slots into a frame and publishes a snapshot with a one-cycle strobe. Used as an in-system display monitor and as the scoreboard front-end in driver benches.

---
 rtl/sseg_capture.sv | 208 ++++++++++++++++++++
 tb/tb_sseg_capture.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_capture.sv
// sseg_capture: receive-side monitor for a four-digit multiplexed seven-segment
// display. Samples the active-low segment/enable bus, ignores multiplex
// transitions and short dwells, decodes each settled slot and publishes
// four-slot frames with a one-cycle frame_valid strobe.
// Optional feature: define SSEG_CAP_BIN_EN to convert each published frame to
// a binary value (otherwise value/value_ok are tied low).
module sseg_capture #(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ssegs,
    input  logic [3:0]  disp_en,
    output logic [15:0] digits,
    output logic [3:0]  dp_vec,
    output logic        frame_valid,
    output logic        all_dash,
    output logic        err,
    output logic        stale,
    output logic [13:0] value,
    output logic        value_ok
);
    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_ARM = CW'(STABLE_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);

    typedef struct packed {
        logic [3:0] code;
        logic       dp;
    } slot_t;

    logic [7:0]    seg_q, seg_p;
    logic [3:0]    en_q, en_p;
    logic [CW-1:0] stab_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          same, en_ok, accept, publish;
    logic [1:0]    slot;
    logic [3:0]    code;
    slot_t [3:0]   shadow;
    logic [3:0]    seen;
    logic [15:0]   pub_digits;
    logic [3:0]    pub_dp;
    logic          pub_dash, pub_err;

    // Sample register plus one-deep history for the stability compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= 8'hFF;
            en_q  <= 4'hF;
            seg_p <= 8'hFF;
            en_p  <= 4'hF;
        end else begin
            seg_q <= ssegs;
            en_q  <= disp_en;
            seg_p <= seg_q;
            en_p  <= en_q;
        end
    end

    assign same = (seg_q == seg_p) && (en_q == en_p);

    // Segment pattern (a..g, active-low) to code nibble.
    always_comb begin
        code = 4'hE;
        case (seg_q[7:1])
            7'h01: code = 4'h0;
            7'h4F: code = 4'h1;
            7'h12: code = 4'h2;
            7'h06: code = 4'h3;
            7'h4C: code = 4'h4;
            7'h24: code = 4'h5;
            7'h20: code = 4'h6;
            7'h0F: code = 4'h7;
            7'h00: code = 4'h8;
            7'h04: code = 4'h9;
            7'h7E: code = 4'hA;
            7'h7F: code = 4'hF;
            default: code = 4'hE;
        endcase
    end

    // Only a single low enable names a slot; idle or overlapping enables do not.
    always_comb begin
        en_ok = 1'b1;
        slot  = 2'd0;
        case (en_q)
            4'b1110: slot = 2'd0;
            4'b1101: slot = 2'd1;
            4'b1011: slot = 2'd2;
            4'b0111: slot = 2'd3;
            default: en_ok = 1'b0;
        endcase
    end

    // Accept fires on the single cycle the counter steps into saturation,
    // so one dwell yields at most one accept.
    assign accept  = same && (stab_cnt == CNT_ARM) && en_ok;
    assign publish = (seen == 4'hF);

    // Stability counter: reload on change, saturate at STABLE_CYC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stab_cnt <= '0;
        else if (!same)
            stab_cnt <= CW'(1);
        else if (stab_cnt != CNT_MAX)
            stab_cnt <= stab_cnt + CW'(1);
    end

    // Shadow slots and seen mask; a publish clears the mask while a coincident
    // accept lands in the fresh frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) shadow[i] <= '{code: 4'hF, dp: 1'b0};
            seen <= '0;
        end else begin
            if (accept) shadow[slot] <= '{code: code, dp: ~seg_q[0]};
            seen <= (publish ? 4'h0 : seen) | (accept ? (4'b0001 << slot) : 4'h0);
        end
    end

    // Frame view of the shadow: slot0 lands in the top nibble.
    always_comb begin
        pub_digits = '0;
        pub_dp     = '0;
        pub_dash   = 1'b1;
        pub_err    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pub_digits[15-4*i -: 4] = shadow[i].code;
            pub_dp[i]               = shadow[i].dp;
            if (shadow[i].code != 4'hA) pub_dash = 1'b0;
            if (shadow[i].code == 4'hE) pub_err  = 1'b1;
        end
    end

    // Published outputs, updated together with the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits      <= 16'hFFFF;
            dp_vec      <= '0;
            frame_valid <= 1'b0;
            all_dash    <= 1'b0;
            err         <= 1'b0;
        end else begin
            frame_valid <= publish;
            if (publish) begin
                digits   <= pub_digits;
                dp_vec   <= pub_dp;
                all_dash <= pub_dash;
                err      <= pub_err;
            end
        end
    end

    // Idle-display watchdog: counts cycles since the last accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            stale   <= 1'b1;
        end else begin
            if (accept)
                tmo_cnt <= '0;
            else if (tmo_cnt != TMO_MAX)
                tmo_cnt <= tmo_cnt + TW'(1);
            if (publish)
                stale <= 1'b0;
            else if (tmo_cnt == TMO_MAX)
                stale <= 1'b1;
        end
    end

`ifdef SSEG_CAP_BIN_EN
    logic [13:0] bin_val;
    logic        bin_ok;

    function automatic logic [13:0] dval(input logic [3:0] c);
        return (c == 4'hF) ? 14'd0 : {10'd0, c};
    endfunction

    assign bin_val = dval(shadow[0].code) * 14'd1000 + dval(shadow[1].code) * 14'd100
                   + dval(shadow[2].code) * 14'd10   + dval(shadow[3].code);

    // Blanks read as leading zeros; the ones slot must hold a numeral.
    always_comb begin
        bin_ok = (shadow[3].code <= 4'd9);
        for (int i = 0; i < 4; i++)
            if (shadow[i].code > 4'd9 && shadow[i].code != 4'hF) bin_ok = 1'b0;
    end

    // Binary value register, updated with the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value    <= '0;
            value_ok <= 1'b0;
        end else if (publish) begin
            value    <= bin_ok ? bin_val : 14'd0;
            value_ok <= bin_ok;
        end
    end
`else
    assign value    = '0;
    assign value_ok = 1'b0;
`endif

endmodule

// File: tb/tb_sseg_capture.sv
// Self-checking bench for sseg_capture: directed scenarios plus randomized
// dwells scored against a dwell-level behavioural model.
module tb_sseg_capture;
    localparam int STABLE_CYC  = 4;
    localparam int TIMEOUT_CYC = 300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ssegs = 8'hFF;
    logic [3:0]  disp_en = 4'hF;
    logic [15:0] digits;
    logic [3:0]  dp_vec;
    logic        frame_valid, all_dash, err, stale, value_ok;
    logic [13:0] value;

    sseg_capture #(.STABLE_CYC(STABLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .ssegs(ssegs), .disp_en(disp_en),
        .digits(digits), .dp_vec(dp_vec), .frame_valid(frame_valid),
        .all_dash(all_dash), .err(err), .stale(stale), .value(value),
        .value_ok(value_ok)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp_vec;
        logic        all_dash;
        logic        err;
        logic [13:0] value;
        logic        value_ok;
    } frame_t;

    frame_t obs_q[$];
    frame_t exp_q[$];
    int n_chk = 0;
    int n_fail = 0;

    // Record every published frame, sampled mid-cycle.
    always @(negedge clk)
        if (frame_valid === 1'b1)
            obs_q.push_back(frame_t'({digits, dp_vec, all_dash, err, value, value_ok}));

    // ---------------- reference model (dwell level) ----------------
    logic [6:0] pat_tbl [12] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24,
                                 7'h20, 7'h0F, 7'h00, 7'h04, 7'h7E, 7'h7F};
    logic [3:0] code_tbl[12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                                 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hF};
    logic [3:0] m_code[4];
    logic       m_dp[4];
    logic [3:0] m_seen;
    logic [7:0] cur_seg;
    logic [3:0] cur_en;
    int         cur_len;
    bit         cur_acc;

    function automatic logic [3:0] decode(input logic [6:0] p);
        for (int k = 0; k < 12; k++) if (pat_tbl[k] == p) return code_tbl[k];
        return 4'hE;
    endfunction

    function automatic int en_slot(input logic [3:0] en);
        int lows = 0, idx = -1;
        for (int i = 0; i < 4; i++) if (!en[i]) begin lows++; idx = i; end
        return (lows == 1) ? idx : -1;
    endfunction

    function automatic frame_t make_frame();
        frame_t f;
        bit ok;
        int v;
        f.digits   = {m_code[0], m_code[1], m_code[2], m_code[3]};
        f.all_dash = 1'b1;
        f.err      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            f.dp_vec[i] = m_dp[i];
            if (m_code[i] != 4'hA) f.all_dash = 1'b0;
            if (m_code[i] == 4'hE) f.err = 1'b1;
        end
`ifdef SSEG_CAP_BIN_EN
        ok = (m_code[3] <= 9);
        v  = 0;
        for (int i = 0; i < 4; i++) begin
            if (!(m_code[i] <= 9 || m_code[i] == 4'hF)) ok = 0;
            v = v * 10 + ((m_code[i] == 4'hF) ? 0 : int'(m_code[i]));
        end
        f.value    = ok ? 14'(v) : 14'd0;
        f.value_ok = ok;
`else
        ok = 0; v = 0;
        f.value    = 14'(v);
        f.value_ok = ok;
`endif
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin m_code[i] = 4'hF; m_dp[i] = 1'b0; end
        m_seen = '0; cur_seg = 8'hFF; cur_en = 4'hF; cur_len = 0; cur_acc = 1;
    endtask

    // A dwell is accepted once if it lasts STABLE_CYC cycles on a single slot.
    task automatic model_dwell(input logic [7:0] seg, input logic [3:0] en, input int len);
        int s;
        if (seg == cur_seg && en == cur_en) cur_len += len;
        else begin cur_seg = seg; cur_en = en; cur_len = len; cur_acc = 0; end
        s = en_slot(en);
        if (!cur_acc && cur_len >= STABLE_CYC && s >= 0) begin
            cur_acc = 1;
            m_code[s] = decode(seg[7:1]);
            m_dp[s] = ~seg[0];
            m_seen[s] = 1'b1;
            if (m_seen == 4'hF) begin exp_q.push_back(make_frame()); m_seen = '0; end
        end
    endtask

    // Drive one dwell; entered and left at posedge+1.
    task automatic dwell(input logic [6:0] pat, input logic dp, input logic [3:0] en, input int len);
        ssegs = {pat, ~dp};
        disp_en = en;
        model_dwell(ssegs, en, len);
        repeat (len) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int len);
        dwell(7'h7F, 1'b0, 4'hF, len);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk += 8;
        if (digits !== 16'hFFFF) begin n_fail++; $display("FAIL reset_digits got %h want ffff", digits); end
        if (dp_vec !== 4'h0) begin n_fail++; $display("FAIL reset_dp got %h want 0", dp_vec); end
        if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv got %b want 0", frame_valid); end
        if (all_dash !== 1'b0) begin n_fail++; $display("FAIL reset_dash got %b want 0", all_dash); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        if (stale !== 1'b1) begin n_fail++; $display("FAIL reset_stale got %b want 1", stale); end
        if (value !== 14'd0) begin n_fail++; $display("FAIL reset_value got %0d want 0", value); end
        if (value_ok !== 1'b0) begin n_fail++; $display("FAIL reset_vok got %b want 0", value_ok); end
        rst_n = 1'b1;
        idle(4);
    endtask

    task automatic test_basic();
        frame_t got, want;
        obs_q.delete(); exp_q.delete();
        dwell(7'h7F, 1'b0, 4'b1110, 8);
        dwell(7'h4F, 1'b0, 4'b1101, 8);
        dwell(7'h12, 1'b1, 4'b1011, 8);
        dwell(7'h06, 1'b0, 4'b0111, 8);
        idle(8);
        n_chk++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_fail++; $display("FAIL basic_count got %0d want 1 (model %0d)", obs_q.size(), exp_q.size());
        end
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q[0]; want = exp_q[0];
            n_chk += 5;
            if (got !== want) begin n_fail++; $display("FAIL basic_frame got %h want %h", got, want); end
            if (got.digits !== 16'hF123) begin n_fail++; $display("FAIL basic_digits got %h want f123", got.digits); end
            if (got.dp_vec !== 4'b0100) begin n_fail++; $display("FAIL basic_dp got %b want 0100", got.dp_vec); end
`ifdef SSEG_CAP_BIN_EN
            if (got.value !== 14'd123) begin n_fail++; $display("FAIL basic_value got %0d want 123", got.value); end
            if (got.value_ok !== 1'b1) begin n_fail++; $display("FAIL basic_vok got %b want 1", got.value_ok); end
`else
            if (got.value !== 14'd0) begin n_fail++; $display("FAIL basic_value got %0d want 0", got.value); end
            if (got.value_ok !== 1'b0) begin n_fail++; $display("FAIL basic_vok got %b want 0", got.value_ok); end
`endif
        end
        n_chk++;
        if (stale !== 1'b0) begin n_fail++; $display("FAIL basic_stale got %b want 0", stale); end
    endtask

    task automatic test_dash();
        frame_t got, want;
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 4; i++) dwell(7'h7E, 1'b0, 4'(~(4'b0001 << i)), 8);
        idle(8);
        n_chk++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_fail++; $display("FAIL dash_count got %0d want 1", obs_q.size());
        end
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q[0]; want = exp_q[0];
            n_chk += 5;
            if (got !== want) begin n_fail++; $display("FAIL dash_frame got %h want %h", got, want); end
            if (got.digits !== 16'hAAAA) begin n_fail++; $display("FAIL dash_digits got %h want aaaa", got.digits); end
            if (got.all_dash !== 1'b1) begin n_fail++; $display("FAIL dash_flag got %b want 1", got.all_dash); end
            if (got.err !== 1'b0) begin n_fail++; $display("FAIL dash_err got %b want 0", got.err); end
            if (got.value_ok !== 1'b0) begin n_fail++; $display("FAIL dash_vok got %b want 0", got.value_ok); end
        end
    endtask

    task automatic test_err();
        frame_t got, want;
        obs_q.delete(); exp_q.delete();
        dwell(7'h4C, 1'b0, 4'b1110, 8);
        dwell(7'h55, 1'b0, 4'b1101, 8);
        dwell(7'h01, 1'b0, 4'b1011, 8);
        dwell(7'h24, 1'b1, 4'b0111, 8);
        idle(8);
        n_chk++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_fail++; $display("FAIL err_count got %0d want 1", obs_q.size());
        end
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q[0]; want = exp_q[0];
            n_chk += 5;
            if (got !== want) begin n_fail++; $display("FAIL err_frame got %h want %h", got, want); end
            if (got.digits !== 16'h4E05) begin n_fail++; $display("FAIL err_digits got %h want 4e05", got.digits); end
            if (got.err !== 1'b1) begin n_fail++; $display("FAIL err_flag got %b want 1", got.err); end
            if (got.dp_vec !== 4'b1000) begin n_fail++; $display("FAIL err_dp got %b want 1000", got.dp_vec); end
            if (got.value_ok !== 1'b0) begin n_fail++; $display("FAIL err_vok got %b want 0", got.value_ok); end
        end
    endtask

    // Dwells of exactly STABLE_CYC are taken, STABLE_CYC-1 are filtered.
    task automatic test_boundary();
        frame_t got, want;
        obs_q.delete(); exp_q.delete();
        dwell(7'h4F, 1'b0, 4'b1110, STABLE_CYC);
        dwell(7'h04, 1'b0, 4'b1101, STABLE_CYC - 1);
        dwell(7'h12, 1'b0, 4'b1101, STABLE_CYC);
        dwell(7'h06, 1'b0, 4'b1011, STABLE_CYC);
        dwell(7'h00, 1'b1, 4'b0111, STABLE_CYC - 1);
        dwell(7'h0F, 1'b0, 4'b0111, STABLE_CYC);
        idle(8);
        n_chk++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_fail++; $display("FAIL bound_count got %0d want 1", obs_q.size());
        end
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q[0]; want = exp_q[0];
            n_chk += 3;
            if (got !== want) begin n_fail++; $display("FAIL bound_frame got %h want %h", got, want); end
            if (got.digits !== 16'h1237) begin n_fail++; $display("FAIL bound_digits got %h want 1237", got.digits); end
            if (got.dp_vec !== 4'b0000) begin n_fail++; $display("FAIL bound_dp got %b want 0000", got.dp_vec); end
        end
    endtask

    // Ghost-length dwells only: nothing accepted, watchdog trips, good frame clears it.
    task automatic test_ghost_stale();
        frame_t got, want;
        obs_q.delete(); exp_q.delete();
        n_chk++;
        if (stale !== 1'b0) begin n_fail++; $display("FAIL ghost_stale0 got %b want 0", stale); end
        for (int k = 0; k < 100; k++) dwell(pat_tbl[k % 10], 1'b0, 4'(~(4'b0001 << (k % 4))), 2);
        n_chk++;
        if (stale !== 1'b0) begin n_fail++; $display("FAIL ghost_stale_early got %b want 0", stale); end
        for (int k = 0; k < 100; k++) dwell(pat_tbl[k % 10], 1'b0, 4'(~(4'b0001 << (k % 4))), 2);
        n_chk += 2;
        if (stale !== 1'b1) begin n_fail++; $display("FAIL ghost_stale_set got %b want 1", stale); end
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL ghost_frames got %0d want 0", obs_q.size()); end
        dwell(7'h24, 1'b0, 4'b1110, 8);
        dwell(7'h20, 1'b0, 4'b1101, 8);
        dwell(7'h0F, 1'b0, 4'b1011, 8);
        dwell(7'h00, 1'b0, 4'b0111, 8);
        idle(8);
        n_chk += 2;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_fail++; $display("FAIL ghost_count got %0d want 1", obs_q.size());
        end
        if (stale !== 1'b0) begin n_fail++; $display("FAIL ghost_stale_clr got %b want 0", stale); end
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q[0]; want = exp_q[0];
            n_chk++;
            if (got !== want) begin n_fail++; $display("FAIL ghost_frame got %h want %h", got, want); end
        end
    endtask

    task automatic test_reset_mid();
        frame_t got, want;
        obs_q.delete(); exp_q.delete();
        dwell(7'h4F, 1'b0, 4'b1110, 6);
        dwell(7'h12, 1'b0, 4'b1101, 6);
        dwell(7'h06, 1'b0, 4'b1011, 6);
        ssegs = 8'hFF; disp_en = 4'hF;
        #2 rst_n = 1'b0;
        model_reset();
        #2;
        n_chk += 4;
        if (digits !== 16'hFFFF) begin n_fail++; $display("FAIL rmid_digits got %h want ffff", digits); end
        if (dp_vec !== 4'h0 || all_dash !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL rmid_flags got dp %b dash %b err %b want 0", dp_vec, all_dash, err);
        end
        if (stale !== 1'b1) begin n_fail++; $display("FAIL rmid_stale got %b want 1", stale); end
        if (value !== 14'd0 || value_ok !== 1'b0) begin
            n_fail++; $display("FAIL rmid_value got %0d/%b want 0/0", value, value_ok);
        end
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        dwell(7'h04, 1'b1, 4'b1110, 8);
        n_chk++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL rmid_early got %0d frames want 0", obs_q.size()); end
        dwell(7'h00, 1'b0, 4'b1101, 8);
        dwell(7'h0F, 1'b0, 4'b1011, 8);
        dwell(7'h20, 1'b0, 4'b0111, 8);
        idle(8);
        n_chk++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_fail++; $display("FAIL rmid_count got %0d want 1", obs_q.size());
        end
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q[0]; want = exp_q[0];
            n_chk += 3;
            if (got !== want) begin n_fail++; $display("FAIL rmid_frame got %h want %h", got, want); end
            if (got.digits !== 16'h9876) begin n_fail++; $display("FAIL rmid_digits2 got %h want 9876", got.digits); end
            if (got.dp_vec !== 4'b0001) begin n_fail++; $display("FAIL rmid_dp got %b want 0001", got.dp_vec); end
        end
    endtask

    task automatic test_random();
        frame_t got, want;
        logic [6:0] p;
        logic [3:0] en;
        int r;
        obs_q.delete(); exp_q.delete();
        for (int k = 0; k < 300; k++) begin
            p = ($urandom_range(0, 3) == 0) ? 7'($urandom) : pat_tbl[$urandom_range(0, 11)];
            r = $urandom_range(0, 7);
            if (r < 6)       en = 4'(~(4'b0001 << $urandom_range(0, 3)));
            else if (r == 6) en = 4'hF;
            else             en = 4'($urandom);
            dwell(p, 1'($urandom), en, $urandom_range(1, 8));
        end
        idle(10);
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            n_chk++;
            if (got !== want) begin n_fail++; $display("FAIL rand_frame got %h want %h", got, want); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dash();
        test_err();
        test_boundary();
        test_ghost_stale();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
